// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the PLL / PLL-clocked core.
// The master side is the sequencer itself; the slave side is the PLL and its consumers.
interface pll_reset_sequencer_if;
    logic       pll_lock;
    logic       pll_resetb;
    logic       core_reset_n;
    logic       ready;
    logic       fault;
    logic [1:0] retry_count;

    modport master (
        input  pll_lock,
        output pll_resetb,
        output core_reset_n,
        output ready,
        output fault,
        output retry_count
    );

    modport slave (
        output pll_lock,
        input  pll_resetb,
        input  core_reset_n,
        input  ready,
        input  fault,
        input  retry_count
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses PLL RESETB, waits for a stable lock, then releases
// the core reset; retries on lock timeout and latches FAULT after too many timeouts.
module pll_reset_sequencer #(
    parameter int PLL_RESET_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 16384,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    pll_reset_sequencer_if.master seq
);
    localparam int CNT_MAX_AB = (PLL_RESET_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RESET_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_AB > LOCK_STABLE_CYCLES) ? CNT_MAX_AB : LOCK_STABLE_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_MAX);

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       retry_reg, retry_next;
    logic             lock_meta_reg, lock_sync_reg;

    logic pll_resetb_reg, pll_resetb_next;
    logic core_reset_n_reg, core_reset_n_next;
    logic ready_reg, ready_next;
    logic fault_reg, fault_next;

    // Two-flop synchronizer; only lock_sync_reg is used below.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_meta_reg <= 1'b0;
            lock_sync_reg <= 1'b0;
        end else begin
            lock_meta_reg <= seq.pll_lock;
            lock_sync_reg <= lock_meta_reg;
        end
    end

    // State, shared counter, retry count and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= HOLD;
            cnt_reg          <= '0;
            retry_reg        <= 2'd0;
            pll_resetb_reg   <= 1'b0;
            core_reset_n_reg <= 1'b0;
            ready_reg        <= 1'b0;
            fault_reg        <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            retry_reg        <= retry_next;
            pll_resetb_reg   <= pll_resetb_next;
            core_reset_n_reg <= core_reset_n_next;
            ready_reg        <= ready_next;
            fault_reg        <= fault_next;
        end
    end

    // Next-state logic; lock loss is tested before count completion so it wins.
    always_comb begin
        state_next = state_reg;
        retry_next = retry_reg;
        case (state_reg)
            HOLD: begin
                if (cnt_reg == HOLD_LAST) begin
                    state_next = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (lock_sync_reg) begin
                    state_next = STABLE;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    if (int'(retry_reg) < MAX_RETRIES) begin
                        retry_next = (retry_reg == 2'd3) ? 2'd3 : retry_reg + 2'd1;
                        state_next = HOLD;
                    end else begin
                        state_next = FAULT;
                    end
                end
            end
            STABLE: begin
                if (!lock_sync_reg) begin
                    state_next = WAIT_LOCK;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next = RUN;
                    retry_next = 2'd0;
                end
            end
            RUN: begin
                if (!lock_sync_reg) begin
                    state_next = HOLD;
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = HOLD;
            end
        endcase
    end

    // The counter restarts on every transition and saturates in RUN/FAULT rather than wrapping.
    always_comb begin
        cnt_next = cnt_reg;
        if (state_next != state_reg) begin
            cnt_next = '0;
        end else if (cnt_reg != CNT_SAT) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Outputs decode the next state so they update on the same edge as the state register.
    always_comb begin
        pll_resetb_next   = 1'b0;
        core_reset_n_next = 1'b0;
        ready_next        = 1'b0;
        fault_next        = 1'b0;
        case (state_next)
            WAIT_LOCK, STABLE: begin
                pll_resetb_next = 1'b1;
            end
            RUN: begin
                pll_resetb_next   = 1'b1;
                core_reset_n_next = 1'b1;
                ready_next        = 1'b1;
            end
            FAULT: begin
                fault_next = 1'b1;
            end
            default: begin
                pll_resetb_next = 1'b0;
            end
        endcase
    end

    assign seq.pll_resetb   = pll_resetb_reg;
    assign seq.core_reset_n = core_reset_n_reg;
    assign seq.ready        = ready_reg;
    assign seq.fault        = fault_reg;
    assign seq.retry_count  = retry_reg;
endmodule
